// File: rtl/vga800_pkg.sv
// Shared constants and types for the 800x600 4bpp VRAM write side.
package vga800_pkg;

    localparam int unsigned LINE_BYTES = 400;
    localparam int unsigned LINES      = 600;
    localparam int unsigned VRAM_AW    = 18;
    localparam int unsigned XW         = 9;
    localparam int unsigned YW         = 10;
    localparam int unsigned CW         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
        logic [CW-1:0] color;
    } fill_cmd_t;

    // Length of [start, start+len) that survives clipping against [0, limit).
    function automatic logic [YW-1:0] clip_len(input logic [YW-1:0] start,
                                               input logic [YW-1:0] len,
                                               input logic [YW-1:0] limit);
        logic [YW-1:0] room;
        if (start >= limit) begin
            clip_len = '0;
        end else begin
            room     = limit - start;
            clip_len = (len < room) ? len : room;
        end
    endfunction

endpackage

// File: rtl/vram_fill.sv
// Rectangle-fill engine: writes a constant byte into a clipped VRAM rectangle,
// one byte per clock, on the VRAM write port.
module vram_fill
    import vga800_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [XW-1:0]      cmd_x,
    input  logic [YW-1:0]      cmd_y,
    input  logic [XW-1:0]      cmd_w,
    input  logic [YW-1:0]      cmd_h,
    input  logic [CW-1:0]      cmd_color,
    output logic               busy,
    output logic               done,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_address,
    output logic [CW-1:0]      vram_data
);

    fill_state_e        state_q, state_d;
    fill_cmd_t          cmd_q, cmd_d;
    logic [XW-1:0]      ew_q, ew_d;
    logic [YW-1:0]      eh_q, eh_d;
    logic [XW-1:0]      col_q, col_d;
    logic [YW-1:0]      row_q, row_d;
    logic [VRAM_AW-1:0] row_base_q, row_base_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               we_q, we_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [CW-1:0]      data_q, data_d;

    logic [XW-1:0]      ew_c;
    logic [YW-1:0]      eh_c;

    // Clipped extents of the latched command.
    assign ew_c = XW'(clip_len(YW'(cmd_q.x), YW'(cmd_q.w), YW'(LINE_BYTES)));
    assign eh_c = clip_len(cmd_q.y, cmd_q.h, YW'(LINES));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        ew_d       = ew_q;
        eh_d       = eh_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid) begin
                    cmd_d.x     = cmd_x;
                    cmd_d.y     = cmd_y;
                    cmd_d.w     = cmd_w;
                    cmd_d.h     = cmd_h;
                    cmd_d.color = cmd_color;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                ew_d       = ew_c;
                eh_d       = eh_c;
                col_d      = '0;
                row_d      = '0;
                row_base_d = VRAM_AW'(cmd_q.y) * VRAM_AW'(LINE_BYTES);
                if ((ew_c == '0) || (eh_c == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = row_base_d + VRAM_AW'(cmd_q.x);
                    data_d  = cmd_q.color;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (col_q == ew_q - XW'(1)) begin
                    if (row_q == eh_q - YW'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        col_d      = '0;
                        row_d      = row_q + YW'(1);
                        row_base_d = row_base_q + VRAM_AW'(LINE_BYTES);
                        we_d       = 1'b1;
                        addr_d     = row_base_d + VRAM_AW'(cmd_q.x);
                    end
                end else begin
                    col_d  = col_q + XW'(1);
                    we_d   = 1'b1;
                    addr_d = addr_q + VRAM_AW'(1);
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any fill in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            ew_q       <= '0;
            eh_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            ew_q       <= ew_d;
            eh_q       <= eh_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign vram_we      = we_q;
    assign vram_address = addr_q;
    assign vram_data    = data_q;

endmodule

// File: tb/tb_vram_fill.sv
// Self-checking bench for vram_fill: cycle-level reference model plus directed
// and randomized fill commands.
module tb_vram_fill;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [8:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [7:0]  cmd_color;
    logic        busy;
    logic        done;
    logic        vram_we;
    logic [17:0] vram_address;
    logic [7:0]  vram_data;

    vram_fill dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_w        (cmd_w),
        .cmd_h        (cmd_h),
        .cmd_color    (cmd_color),
        .busy         (busy),
        .done         (done),
        .vram_we      (vram_we),
        .vram_address (vram_address),
        .vram_data    (vram_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: on accept, list every address the rectangle covers
    // inside the 400x600 screen; outputs then follow a fixed cycle schedule.
    int        cyc = 0;
    bit        m_valid = 0;
    bit        m_active = 0;
    int        m_n = 0;
    int        exp_q[$];
    logic [7:0] m_color = '0;
    int        acc_cnt = 0;

    function automatic bit model_ready(input int c);
        return m_valid && (!m_active || (c - m_n) >= 3 + exp_q.size());
    endfunction

    always @(posedge clock) begin
        int c;
        c = cyc;
        if (reset) begin
            m_valid  = 1;
            m_active = 0;
        end else if (cmd_valid && model_ready(c)) begin
            exp_q.delete();
            for (int r = 0; r < int'(cmd_h); r++)
                for (int k = 0; k < int'(cmd_w); k++)
                    if (int'(cmd_x) + k < 400 && int'(cmd_y) + r < 600)
                        exp_q.push_back((int'(cmd_y) + r) * 400 + int'(cmd_x) + k);
            m_color  = cmd_color;
            m_n      = c;
            m_active = 1;
            acc_cnt++;
        end
        cyc = c + 1;
    end

    // Per-cycle comparison against the model, plus a log of DUT writes.
    int wr_log[$];
    int done_cnt = 0;
    int last_done_cyc = 0;

    always @(negedge clock) begin
        int k, n;
        if (vram_we) wr_log.push_back(int'(vram_address));
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (m_valid) begin
            n = exp_q.size();
            k = cyc - m_n;
            if (!m_active || k >= 3 + n) begin
                chk("idle_ready", cmd_ready, 1);
                chk("idle_busy",  busy, 0);
                chk("idle_done",  done, 0);
                chk("idle_we",    vram_we, 0);
            end else begin
                chk("act_ready", cmd_ready, 0);
                chk("act_busy",  busy, 1);
                chk("act_done",  done, (k == 2 + n) ? 1 : 0);
                if (k >= 2 && k <= 1 + n) begin
                    chk("act_we",   vram_we, 1);
                    chk("act_addr", vram_address, exp_q[k-2]);
                    chk("act_data", vram_data, m_color);
                end else begin
                    chk("act_we", vram_we, 0);
                end
            end
        end
    end

    task automatic set_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] col);
        cmd_x     = 9'(x);
        cmd_y     = 10'(y);
        cmd_w     = 9'(w);
        cmd_h     = 10'(h);
        cmd_color = col;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int start;
        bit got;
        start = acc_cnt;
        got   = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clock);
            #2;
            if (acc_cnt != start) got = 1;
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int start;
        bit got;
        start = done_cnt;
        got   = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clock);
            #2;
            if (done_cnt != start) got = 1;
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [7:0] col);
        wr_log.delete();
        set_cmd(x, y, w, h, col);
        wait_accept();
        cmd_valid = 1'b0;
        wait_done();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int lit2[6];
        int n1, n_first;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        do_reset(3);
        @(negedge clock);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_we",    vram_we, 0);
        chk("rst_addr",  vram_address, 0);
        chk("rst_data",  vram_data, 0);
        @(posedge clock); #2;

        // Single pixel byte.
        run_cmd(0, 0, 1, 1, 8'hA5);
        chk("t1_nwr", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("t1_addr", wr_log[0], 0);
        chk("t1_done_lat", last_done_cyc - m_n, 3);

        // Small 3x2 rectangle.
        run_cmd(10, 2, 3, 2, 8'h3C);
        lit2 = '{810, 811, 812, 1210, 1211, 1212};
        chk("t2_nwr", wr_log.size(), 6);
        if (wr_log.size() == 6)
            for (int i = 0; i < 6; i++) chk("t2_addr", wr_log[i], lit2[i]);
        chk("t2_done_lat", last_done_cyc - m_n, 8);

        // Bottom-right corner clip.
        run_cmd(398, 599, 5, 4, 8'h77);
        chk("t3_nwr", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("t3_addr0", wr_log[0], 239998);
            chk("t3_addr1", wr_log[1], 239999);
        end
        chk("t3_done_lat", last_done_cyc - m_n, 4);

        // Degenerate and fully clipped commands.
        run_cmd(5, 5, 0, 3, 8'h11);
        chk("t4a_nwr", wr_log.size(), 0);
        chk("t4a_done_lat", last_done_cyc - m_n, 2);
        run_cmd(400, 5, 10, 3, 8'h22);
        chk("t4b_nwr", wr_log.size(), 0);
        chk("t4b_done_lat", last_done_cyc - m_n, 2);
        run_cmd(5, 600, 10, 3, 8'h33);
        chk("t4c_nwr", wr_log.size(), 0);
        chk("t4c_done_lat", last_done_cyc - m_n, 2);

        // Reset during the third write of a 4x4 fill.
        begin
            bit hit;
            int dstart;
            wr_log.delete();
            set_cmd(5, 5, 4, 4, 8'h5A);
            wait_accept();
            cmd_valid = 1'b0;
            dstart = done_cnt;
            hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clock);
                #1;
                if (wr_log.size() >= 3) hit = 1;
            end
            chk("t5_reached_3rd", hit, 1);
            reset = 1'b1;
            @(posedge clock); #2;
            reset = 1'b0;
            @(negedge clock);
            chk("t5_we_low", vram_we, 0);
            chk("t5_ready",  cmd_ready, 1);
            chk("t5_busy",   busy, 0);
            repeat (3) @(negedge clock);
            chk("t5_no_done", done_cnt, dstart);
            @(posedge clock); #2;
            run_cmd(1, 1, 2, 1, 8'hC3);
            chk("t5_new_nwr", wr_log.size(), 2);
        end

        // Back-to-back commands with cmd_valid held high.
        wr_log.delete();
        set_cmd(0, 10, 3, 2, 8'h01);
        wait_accept();
        n_first = m_n;
        n1 = exp_q.size();
        set_cmd(20, 20, 2, 2, 8'h02);
        wait_accept();
        cmd_valid = 1'b0;
        chk("t6_accept_gap", m_n - n_first, 3 + n1);
        wait_done();
        chk("t6_nwr", wr_log.size(), 10);

        // Randomized commands, some biased onto the clip edges, fields scrambled while busy.
        for (int t = 0; t < 60; t++) begin
            int x, y, w, h;
            case ($urandom_range(0, 3))
                0:       begin x = $urandom_range(380, 511); y = $urandom_range(0, 50); end
                1:       begin x = $urandom_range(0, 399);   y = $urandom_range(585, 700); end
                default: begin x = $urandom_range(0, 511);   y = $urandom_range(0, 1023); end
            endcase
            w = $urandom_range(0, 24);
            h = $urandom_range(0, 6);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #2;
            set_cmd(x, y, w, h, 8'($urandom));
            wait_accept();
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_x = 9'($urandom); cmd_y = 10'($urandom);
            cmd_w = 9'($urandom_range(0, 24)); cmd_h = 10'($urandom_range(0, 6));
            cmd_color = 8'($urandom);
            if (!cmd_valid) wait_done();
        end
        cmd_valid = 1'b0;
        repeat (400) @(posedge clock);
        #2;
        chk("final_idle_ready", cmd_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
